timecode_record_writer: RTL and testbench

TIMECODE_RECORD_WRITER -- requirements
Module: timecode_record_writer

---
 rtl/timecode_pkg.sv | 47 ++++
 rtl/tc_bcd_counter.sv | 51 +++++
 rtl/timecode_record_writer.sv | 150 +++++++++++++++
 tb/tb_timecode_record_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timecode_pkg.sv
// timecode_pkg -- shared types and constants for the timecode record writer.
//   fps_e        : fps_sel encoding (00=24, 01=25, 10/11=30)
//   tc_state_e   : record emitter FSM states
//   bcd_t        : one two-digit packed-BCD time field
//   fps_ff_max   : highest FF value for a given fps_sel
//   bcd_at_wrap  : field is at/above its maximum or holds a non-BCD digit
package timecode_pkg;

    localparam int TC_ADDR_W    = 13;
    localparam int TC_DATA_W    = 8;
    localparam int RECORD_BYTES = 4;

    typedef logic [7:0] bcd_t;

    typedef enum logic [1:0] {
        FPS_24  = 2'b00,
        FPS_25  = 2'b01,
        FPS_30  = 2'b10,
        FPS_30B = 2'b11
    } fps_e;

    typedef enum logic [2:0] {
        IDLE,
        EMIT0,
        EMIT1,
        EMIT2,
        EMIT3
    } tc_state_e;

    localparam bcd_t SSMM_MAX = 8'h59;
    localparam bcd_t HH_MAX   = 8'h23;

    function automatic bcd_t fps_ff_max(input logic [1:0] sel);
        case (sel)
            FPS_24:  return 8'h23;
            FPS_25:  return 8'h24;
            default: return 8'h29;
        endcase
    endfunction

    // For valid BCD the raw code orders like the decimal value, so a plain
    // compare works; any non-BCD digit counts as out of range and wraps.
    function automatic logic bcd_at_wrap(input bcd_t v, input bcd_t max_v);
        return (v >= max_v) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
    endfunction

endpackage

// File: rtl/tc_bcd_counter.sv
// tc_bcd_counter -- one two-digit packed-BCD time field.
//   clk, reset : clock, async active-high reset (field clears to 00)
//   inc        : advance by one this edge
//   load       : load load_val (wins over inc)
//   max_val    : last legal value; incrementing from it (or from any
//                out-of-range value) loads wrap_val and raises carry
//   wrap_val   : value taken on wrap (00, or 02 for a dropped FF pair)
//   value      : registered field, value_nxt : value after this edge
//   carry      : this increment wraps the field
module tc_bcd_counter
    import timecode_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  bcd_t load_val,
    input  bcd_t max_val,
    input  bcd_t wrap_val,
    output bcd_t value,
    output bcd_t value_nxt,
    output logic carry
);

    logic at_wrap;

    assign at_wrap = bcd_at_wrap(value, max_val);
    assign carry   = inc & ~load & at_wrap;

    always_comb begin
        value_nxt = value;
        if (load)
            value_nxt = load_val;
        else if (inc) begin
            if (at_wrap)
                value_nxt = wrap_val;
            else if (value[3:0] == 4'd9)
                value_nxt = {value[7:4] + 4'd1, 4'd0};
            else
                value_nxt = {value[7:4], value[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else
            value <= value_nxt;
    end

endmodule

// File: rtl/timecode_record_writer.sv
// timecode_record_writer -- keeps HH:MM:SS:FF time and writes a 4-byte
// record {FF,SS,MM,HH} to timecode memory after every frame tick.
//   clk, reset         : clock, async active-high reset
//   frame_tick         : advance time one frame and emit a record
//   fps_sel            : 00=24, 01=25, 1x=30 fps
//   preset_load        : load preset_bcd {HH,MM,SS,FF}; suppresses a tick
//   drop_frame         : drop-frame counting at 30 fps (TC_DROP_FRAME_EN only)
//   timecode_data      : record byte, timecode_valid qualifies it
//   timecode_address   : 13-bit byte write pointer, wraps 8191->0
//   busy               : record in flight or queued
//   overflow           : sticky, a queued record was replaced before emission
// Optional feature macro: TC_DROP_FRAME_EN.
module timecode_record_writer
    import timecode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [1:0]           fps_sel,
    input  logic                 preset_load,
    input  logic [31:0]          preset_bcd,
`ifdef TC_DROP_FRAME_EN
    input  logic                 drop_frame,
`endif
    output logic [TC_DATA_W-1:0] timecode_data,
    output logic                 timecode_valid,
    output logic [TC_ADDR_W-1:0] timecode_address,
    output logic                 busy,
    output logic                 overflow
);

    typedef logic [RECORD_BYTES-1:0][TC_DATA_W-1:0] rec_t;

    tc_state_e state, state_nxt;
    logic      tick;
    bcd_t      ff, ss, mm, hh;
    bcd_t      ff_nxt, ss_nxt, mm_nxt, hh_nxt;
    logic      ff_carry, ss_carry, mm_carry, hh_carry_unused;
    logic      df_active, df_skip;
    bcd_t      ff_wrap_val;
    rec_t      time_rec, snap, cur_rec, rec_nxt;
    logic      pending;
    logic [TC_DATA_W-1:0] data_nxt;
    logic      valid_nxt;

    assign tick = frame_tick & ~preset_load;

`ifdef TC_DROP_FRAME_EN
    assign df_active = drop_frame & fps_sel[1];
`else
    assign df_active = 1'b0;
`endif

    // Frames 00/01 are skipped when this tick rolls into a new minute that
    // is not a multiple of ten: SS wraps, MM does not, and MM's units digit
    // is not 9 (which would land on x0).
    assign df_skip = df_active && bcd_at_wrap(ss, SSMM_MAX) &&
                     !bcd_at_wrap(mm, SSMM_MAX) && (mm[3:0] != 4'd9);
    assign ff_wrap_val = df_skip ? 8'h02 : 8'h00;

    tc_bcd_counter u_ff (
        .clk(clk), .reset(reset), .inc(tick), .load(preset_load),
        .load_val(preset_bcd[7:0]), .max_val(fps_ff_max(fps_sel)),
        .wrap_val(ff_wrap_val), .value(ff), .value_nxt(ff_nxt), .carry(ff_carry)
    );
    tc_bcd_counter u_ss (
        .clk(clk), .reset(reset), .inc(ff_carry), .load(preset_load),
        .load_val(preset_bcd[15:8]), .max_val(SSMM_MAX),
        .wrap_val(8'h00), .value(ss), .value_nxt(ss_nxt), .carry(ss_carry)
    );
    tc_bcd_counter u_mm (
        .clk(clk), .reset(reset), .inc(ss_carry), .load(preset_load),
        .load_val(preset_bcd[23:16]), .max_val(SSMM_MAX),
        .wrap_val(8'h00), .value(mm), .value_nxt(mm_nxt), .carry(mm_carry)
    );
    tc_bcd_counter u_hh (
        .clk(clk), .reset(reset), .inc(mm_carry), .load(preset_load),
        .load_val(preset_bcd[31:24]), .max_val(HH_MAX),
        .wrap_val(8'h00), .value(hh), .value_nxt(hh_nxt), .carry(hh_carry_unused)
    );

    // Post-increment time as a record; FF carries the drop-frame flag in bit 6.
    assign time_rec = {hh_nxt, mm_nxt, ss_nxt, 1'b0, df_active, ff_nxt[5:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A tick landing in EMIT3 chains straight into the next record.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = EMIT0;
            EMIT0:   state_nxt = EMIT1;
            EMIT1:   state_nxt = EMIT2;
            EMIT2:   state_nxt = EMIT3;
            EMIT3:   state_nxt = (pending || tick) ? EMIT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Entering EMIT0 picks the freshest time: this edge's tick if any,
    // otherwise the queued snapshot.
    always_comb begin
        rec_nxt = cur_rec;
        if (state_nxt == EMIT0)
            rec_nxt = tick ? time_rec : snap;
        valid_nxt = (state_nxt != IDLE);
        case (state_nxt)
            EMIT0:   data_nxt = rec_nxt[0];
            EMIT1:   data_nxt = rec_nxt[1];
            EMIT2:   data_nxt = rec_nxt[2];
            EMIT3:   data_nxt = rec_nxt[3];
            default: data_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_rec          <= '0;
            snap             <= '0;
            pending          <= 1'b0;
            overflow         <= 1'b0;
            timecode_data    <= '0;
            timecode_valid   <= 1'b0;
            timecode_address <= '0;
        end else begin
            cur_rec        <= rec_nxt;
            timecode_data  <= data_nxt;
            timecode_valid <= valid_nxt;
            if (timecode_valid)
                timecode_address <= timecode_address + TC_ADDR_W'(1);
            // EMIT3 always drains the queue (a tick there is emitted directly).
            if (state == EMIT3)
                pending <= 1'b0;
            else if (tick && state != IDLE) begin
                pending <= 1'b1;
                snap    <= time_rec;
            end
            if (tick && pending)
                overflow <= 1'b1;
        end
    end

    assign busy = (state != IDLE) || pending;

endmodule

// File: tb/tb_timecode_record_writer.sv
module tb_timecode_record_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [1:0]  fps_sel;
    logic        preset_load;
    logic [31:0] preset_bcd;
`ifdef TC_DROP_FRAME_EN
    logic        drop_frame;
`endif
    logic [7:0]  timecode_data;
    logic        timecode_valid;
    logic [12:0] timecode_address;
    logic        busy;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timecode_record_writer dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .fps_sel(fps_sel),
        .preset_load(preset_load),
        .preset_bcd(preset_bcd),
`ifdef TC_DROP_FRAME_EN
        .drop_frame(drop_frame),
`endif
        .timecode_data(timecode_data),
        .timecode_valid(timecode_valid),
        .timecode_address(timecode_address),
        .busy(busy),
        .overflow(overflow)
    );

    // ---------------- reference model ----------------
    // Time as four BCD bytes; output as a byte stream queue. A record goes
    // straight to the stream if nothing is streaming, else it waits in a
    // single holding slot (replacing an older one sets overflow).
    logic [7:0]  m_ff, m_ss, m_mm, m_hh;
    logic [7:0]  m_q[$];
    int          m_addr;
    bit          m_pend;
    bit          m_ovf;
    logic [31:0] m_prec;

    function automatic logic [8:0] adv(input logic [7:0] v, input int maxd);
        int n;
        if (v[7:4] > 9 || v[3:0] > 9) return 9'h100;
        n = v[7:4] * 10 + v[3:0];
        if (n >= maxd) return 9'h100;
        n = n + 1;
        return {1'b0, 4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] rand_bcd(input int maxd);
        int n;
        n = int'($urandom_range(0, maxd));
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_addr = 0;
        m_pend = 0;
        m_ovf  = 0;
        {m_hh, m_mm, m_ss, m_ff} = 32'h0;
        m_prec = 32'h0;
    endtask

    task automatic push_rec(input logic [31:0] rec);
        m_q.push_back(rec[7:0]);
        m_q.push_back(rec[15:8]);
        m_q.push_back(rec[23:16]);
        m_q.push_back(rec[31:24]);
    endtask

    task automatic model_edge(input bit tk, input bit ld, input logic [31:0] pv, input logic [1:0] fs);
        logic [8:0]  r;
        bit          cf;
        bit          df;
        int          ffmax;
        logic [31:0] rec;
        if (m_q.size() != 0) begin
            void'(m_q.pop_front());
            m_addr = (m_addr + 1) % 8192;
        end
        if (ld) begin
            {m_hh, m_mm, m_ss, m_ff} = pv;
        end else if (tk) begin
            ffmax = (fs == 2'b00) ? 23 : (fs == 2'b01) ? 24 : 29;
            r = adv(m_ff, ffmax); cf = r[8]; m_ff = r[7:0];
            if (cf) begin
                r = adv(m_ss, 59); m_ss = r[7:0];
                if (r[8]) begin
                    r = adv(m_mm, 59); m_mm = r[7:0];
                    if (r[8]) begin
                        r = adv(m_hh, 23); m_hh = r[7:0];
                    end
                end
            end
            df = 1'b0;
`ifdef TC_DROP_FRAME_EN
            df = drop_frame && fs[1];
            if (df && cf && m_ss == 8'h00 && m_mm[3:0] != 4'h0) m_ff = 8'h02;
`endif
            rec = {m_hh, m_mm, m_ss, 1'b0, df, m_ff[5:0]};
            if (m_q.size() == 0 && !m_pend) begin
                push_rec(rec);
            end else begin
                if (m_pend) m_ovf = 1'b1;
                m_pend = 1'b1;
                m_prec = rec;
            end
        end
        if (m_q.size() == 0 && m_pend) begin
            push_rec(m_prec);
            m_pend = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model.
    task automatic cyc(input bit tk, input bit ld, input logic [31:0] pv, input logic [1:0] fs);
        frame_tick  = tk;
        preset_load = ld;
        preset_bcd  = pv;
        fps_sel     = fs;
        @(posedge clk);
        model_edge(tk, ld, pv, fs);
        #1;
        chk("m_valid", 32'(timecode_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("m_data", 32'(timecode_data), 32'(m_q[0]));
        chk("m_addr", 32'(timecode_address), 32'(m_addr));
        chk("m_busy", 32'(busy), 32'(m_q.size() != 0 || m_pend));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        frame_tick  = 1'b0;
        preset_load = 1'b0;
    endtask

    typedef struct {
        bit          tk;
        bit          ld;
        logic [31:0] pv;
        logic [1:0]  fs;
        bit          ev;
        logic [7:0]  ed;
        int          ea;
        bit          eb;
        bit          eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit tk, input bit ld, input logic [31:0] pv, input logic [1:0] fs,
                       input bit ev, input logic [7:0] ed, input int ea, input bit eb, input bit eo);
        vec_t v;
        v.tk = tk; v.ld = ld; v.pv = pv; v.fs = fs;
        v.ev = ev; v.ed = ed; v.ea = ea; v.eb = eb; v.eo = eo;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] pv;
        logic [1:0]  fs;
        bit          tk, ld;

        reset = 1'b1; frame_tick = 1'b0; preset_load = 1'b0; preset_bcd = '0; fps_sel = 2'b01;
`ifdef TC_DROP_FRAME_EN
        drop_frame = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(timecode_valid), 0);
        chk("rst_data", 32'(timecode_data), 0);
        chk("rst_addr", 32'(timecode_address), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b0;

        // single tick at 25 fps from 00:00:00:00
        add(1,0,0,1, 1,8'h01,0,1,0);
        add(0,0,0,1, 1,8'h00,1,1,0);
        add(0,0,0,1, 1,8'h00,2,1,0);
        add(0,0,0,1, 1,8'h00,3,1,0);
        add(0,0,0,1, 0,8'h00,4,0,0);
        // 23:59:59:24 rolls over to midnight
        add(0,1,32'h23595924,1, 0,8'h00,4,0,0);
        add(1,0,0,1, 1,8'h00,4,1,0);
        add(0,0,0,1, 1,8'h00,5,1,0);
        add(0,0,0,1, 1,8'h00,6,1,0);
        add(0,0,0,1, 1,8'h00,7,1,0);
        add(0,0,0,1, 0,8'h00,8,0,0);
        // ticks at N and N+2: back-to-back records
        add(1,0,0,1, 1,8'h01,8,1,0);
        add(0,0,0,1, 1,8'h00,9,1,0);
        add(1,0,0,1, 1,8'h00,10,1,0);
        add(0,0,0,1, 1,8'h00,11,1,0);
        add(0,0,0,1, 1,8'h02,12,1,0);
        add(0,0,0,1, 1,8'h00,13,1,0);
        add(0,0,0,1, 1,8'h00,14,1,0);
        add(0,0,0,1, 1,8'h00,15,1,0);
        add(0,0,0,1, 0,8'h00,16,0,0);
        // ticks at N, N+1, N+2: middle record dropped
        add(1,0,0,1, 1,8'h03,16,1,0);
        add(1,0,0,1, 1,8'h00,17,1,0);
        add(1,0,0,1, 1,8'h00,18,1,1);
        add(0,0,0,1, 1,8'h00,19,1,1);
        add(0,0,0,1, 1,8'h05,20,1,1);
        add(0,0,0,1, 1,8'h00,21,1,1);
        add(0,0,0,1, 1,8'h00,22,1,1);
        add(0,0,0,1, 1,8'h00,23,1,1);
        add(0,0,0,1, 0,8'h00,24,0,1);
        // FF=28 loaded at 30 fps, then ticked at 24 fps: wraps with carry
        add(0,1,32'h00000028,2, 0,8'h00,24,0,1);
        add(1,0,0,0, 1,8'h00,24,1,1);
        add(0,0,0,0, 1,8'h01,25,1,1);
        add(0,0,0,0, 1,8'h00,26,1,1);
        add(0,0,0,0, 1,8'h00,27,1,1);
        add(0,0,0,0, 0,8'h00,28,0,1);
        // load beats a simultaneous tick; non-BCD SS wraps on carry
        add(1,1,32'h00007A24,1, 0,8'h00,28,0,1);
        add(1,0,0,1, 1,8'h00,28,1,1);
        add(0,0,0,1, 1,8'h00,29,1,1);
        add(0,0,0,1, 1,8'h01,30,1,1);
        add(0,0,0,1, 1,8'h00,31,1,1);
        add(0,0,0,1, 0,8'h00,32,0,1);
        // non-BCD SS is kept as loaded when not carried into
        add(0,1,32'h00007A05,1, 0,8'h00,32,0,1);
        add(1,0,0,1, 1,8'h06,32,1,1);
        add(0,0,0,1, 1,8'h7A,33,1,1);
        add(0,0,0,1, 1,8'h00,34,1,1);
        add(0,0,0,1, 1,8'h00,35,1,1);
        add(0,0,0,1, 0,8'h00,36,0,1);

        foreach (tbl[i]) begin
            cyc(tbl[i].tk, tbl[i].ld, tbl[i].pv, tbl[i].fs);
            chk($sformatf("tv%0d_valid", i), 32'(timecode_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tv%0d_data", i), 32'(timecode_data), 32'(tbl[i].ed));
            chk($sformatf("tv%0d_addr", i), 32'(timecode_address), 32'(tbl[i].ea));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("tv%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
        end

`ifdef TC_DROP_FRAME_EN
        drop_frame = 1'b1;
        cyc(0, 1, 32'h00005929, 2'b10);
        cyc(1, 0, 0, 2'b10);
        chk("df_ff", 32'(timecode_data), 32'h42);
        cyc(0, 0, 0, 2'b10);
        chk("df_ss", 32'(timecode_data), 32'h00);
        cyc(0, 0, 0, 2'b10);
        chk("df_mm", 32'(timecode_data), 32'h01);
        cyc(0, 0, 0, 2'b10);
        cyc(0, 0, 0, 2'b10);
`endif

        // randomized traffic against the model
        fs = 2'b01;
        for (int n = 0; n < 1500; n++) begin
            tk = ($urandom_range(0, 99) < 40);
            ld = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 5) fs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8)
                pv = {rand_bcd(23), rand_bcd(59), rand_bcd(59), rand_bcd(29)};
            else
                pv = $urandom;
`ifdef TC_DROP_FRAME_EN
            drop_frame = 1'($urandom_range(0, 1));
`endif
            cyc(tk, ld, pv, fs);
        end

        // address wrap: 2049 contiguous records from a fresh reset
`ifdef TC_DROP_FRAME_EN
        drop_frame = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r <= 2048; r++) begin
            cyc(1, 0, 0, 2'b01);
            if (r == 2048) begin
                chk("wrap_addr0", 32'(timecode_address), 0);
                chk("wrap_valid", 32'(timecode_valid), 1);
            end
            for (int j = 1; j <= 3; j++) begin
                cyc(0, 0, 0, 2'b01);
                if (r == 2047 && j == 2) chk("addr_8190", 32'(timecode_address), 8190);
            end
        end
        cyc(0, 0, 0, 2'b01);

        // reset in EMIT1 aborts the record at once
        cyc(1, 0, 0, 2'b01);
        cyc(0, 0, 0, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(timecode_valid), 0);
        chk("abort_addr", 32'(timecode_address), 0);
        chk("abort_busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) cyc(0, 0, 0, 2'b01);
        cyc(1, 0, 0, 2'b01);
        chk("post_rst_ff", 32'(timecode_data), 32'h01);
        repeat (4) cyc(0, 0, 0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
